sha256_miner_ctrl: RTL and testbench
====================================

SHA256_MINER_CTRL -- requirements
Module: sha256_miner_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  pulse: latch job; accepted only when busy=0.
REQ-005 abort  in  1  level: return to IDLE at next edge.
REQ-006 midstate  in  256  SHA-256 state after header chunk 1; word a at [31:0], h at [255:224].
REQ-007 tail  in  96  header bytes 64..75 (merkle tail, time, bits); byte 64 at [7:0].
REQ-008 nonce_start  in  32  first nonce tried.
REQ-009 nonce_end  in  32  last nonce tried (inclusive).
REQ-010 core_data  out  512  to sha256_chunk data; message word i byte-reversed at [32i+31:32i].
REQ-011 core_vin  out  256  to sha256_chunk V_in; word a at [31:0].
REQ-012 core_hash  in  256  from sha256_chunk hash; word a at [255:224], h at [31:0].
REQ-013 core_valid  in  1  from sha256_chunk valid; one cycle in 64; core latches core_data/core_vin on this edge.
REQ-014 busy  out  1  job latched and not finished.
REQ-015 found  out  1  one-cycle pulse: share found.
REQ-016 found_nonce  out  32  nonce of last share; held until next share.
REQ-017 done  out  1  one-cycle pulse: nonce_end evaluated.
REQ-018 cur_nonce  out  32  nonce currently in pass 1/pass 2.

Function
REQ-019 States: IDLE, WAIT, P1, P2; advance only on cycles with core_valid=1, except start/abort.
REQ-020 IDLE + start -> WAIT; latch midstate, tail, nonce_start into cur_nonce, nonce_end; busy=1 next cycle.
REQ-021 start while busy=1: ignored, no latched field changes.
REQ-022 WAIT + core_valid: drive pass-1 inputs -> P1; start coinciding with core_valid waits for the following core_valid.
REQ-023 Pass 1: core_vin=midstate; core_data[95:0]=tail, [127:96]=cur_nonce, message word 4=0x80000000, words 5-14=0, word 15=0x00000280.
REQ-024 P1 + core_valid: drive pass-2 inputs combinationally from core_hash in same cycle -> P2.
REQ-025 Pass 2: core_vin=SHA-256 IV (a=0x6a09e667 ... h=0x5be0cd19); message words 0-7=core_hash a..h, word 8=0x80000000, words 9-14=0, word 15=0x00000100.
REQ-026 P2 + core_valid: evaluate core_hash[31:0]; ==0 -> found=1 next cycle, found_nonce=cur_nonce.
REQ-027 P2 + core_valid, cur_nonce!=nonce_end: cur_nonce+1 (mod 2^32), drive pass 1 same cycle -> P1; throughput 128 cycles/nonce.
REQ-028 P2 + core_valid, cur_nonce==nonce_end: done=1 next cycle, busy=0 -> IDLE; found and done pulse together if last nonce hits.
REQ-029 nonce wraps 0xffffffff->0; nonce_end<nonce_start covers the wrapped range; nonce_start==nonce_end tries exactly one nonce.
REQ-030 abort: -> IDLE, busy=0, no found/done pulse, found_nonce retained; abort beats start in same cycle.
REQ-031 In IDLE/WAIT, core_data=0 and core_vin=0; core results are ignored.

Reset
REQ-032 reset: state IDLE; busy, found, done=0; found_nonce, cur_nonce=0; core_data, core_vin=0.
REQ-033 reset mid-job drops job without found/done; dominates start and abort.

Verification
REQ-034 Genesis header (midstate from software model; tail = merkle tail, time 0x495fab29, bits 0x1d00ffff), nonce_start=nonce_end=0x7c2bac1d -> found and done same cycle, found_nonce=0x7c2bac1d, 128-192 cycles after start.
REQ-035 Same job, nonce_start=0x7c2bac1b, nonce_end=0x7c2bac1f -> exactly one found (0x7c2bac1d), done after 5x128 cycles of passes.
REQ-036 nonce_start=0xfffffffe, nonce_end=0x00000001 -> cur_nonce sequence fffffffe, ffffffff, 0, 1; one done.
REQ-037 start pulsed while busy with different nonce_start -> ignored; cur_nonce unchanged.
REQ-038 abort in P2 one cycle before core_valid -> IDLE, no found/done; new start then runs normally.
REQ-039 reset asserted in P1 -> all outputs at reset values next cycle; core_data=0.

Source files
------------

// File: rtl/sha256_miner_ctrl.sv
// Nonce-scanning controller for a 64-cycle SHA-256 chunk core: feeds header pass 1 and
// digest pass 2 alternately, and flags nonces whose final hash word h is zero.
module sha256_miner_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] midstate,
    input  logic [95:0]  tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic [511:0] core_data,
    output logic [255:0] core_vin,
    input  logic [255:0] core_hash,
    input  logic         core_valid,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic         done,
    output logic [31:0]  cur_nonce
);

    typedef enum logic [1:0] {IDLE, WAIT, P1, P2} state_t;

    // SHA-256 initial hash value, word a in the low bits to match core_vin ordering.
    localparam logic [255:0] SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    state_t        state, state_nx;
    logic [255:0]  mid_q;
    logic [95:0]   tail_q;
    logic [31:0]   end_q;
    logic [31:0]   nonce_nx;
    logic          found_nx, done_nx;
    logic          accept_job;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Second header chunk: 12 tail bytes, nonce, padding, 640-bit length.
    function automatic logic [511:0] pass1_data(input logic [95:0] t, input logic [31:0] n);
        logic [511:0] d;
        d          = '0;
        d[95:0]    = t;
        d[127:96]  = n;
        d[159:128] = bswap32(32'h80000000);
        d[511:480] = bswap32(32'h00000280);
        return d;
    endfunction

    // Digest of pass 1 re-hashed as a 256-bit message with padding and length.
    function automatic logic [511:0] pass2_data(input logic [255:0] h);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[32*i +: 32] = bswap32(h[255-32*i -: 32]);
        end
        d[287:256] = bswap32(32'h80000000);
        d[511:480] = bswap32(32'h00000100);
        return d;
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_nx   = state;
        nonce_nx   = cur_nonce;
        found_nx   = 1'b0;
        done_nx    = 1'b0;
        accept_job = 1'b0;
        core_data  = '0;
        core_vin   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_job = 1'b1;
                    nonce_nx   = nonce_start;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                if (core_valid) begin
                    core_data = pass1_data(tail_q, cur_nonce);
                    core_vin  = mid_q;
                    state_nx  = P1;
                end
            end
            P1: begin
                if (core_valid) begin
                    core_data = pass2_data(core_hash);
                    core_vin  = SHA_IV;
                    state_nx  = P2;
                end
            end
            P2: begin
                if (core_valid) begin
                    found_nx = (core_hash[31:0] == 32'd0);
                    if (cur_nonce == end_q) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        nonce_nx  = cur_nonce + 32'd1;
                        core_data = pass1_data(tail_q, nonce_nx);
                        core_vin  = mid_q;
                        state_nx  = P1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Abort (and reset) cancel everything decided above, including a pending start.
        if (abort || reset) begin
            state_nx   = IDLE;
            nonce_nx   = cur_nonce;
            found_nx   = 1'b0;
            done_nx    = 1'b0;
            accept_job = 1'b0;
            core_data  = '0;
            core_vin   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            found       <= 1'b0;
            done        <= 1'b0;
            found_nonce <= 32'd0;
            cur_nonce   <= 32'd0;
        end else begin
            state     <= state_nx;
            found     <= found_nx;
            done      <= done_nx;
            cur_nonce <= nonce_nx;
            if (found_nx) begin
                found_nonce <= cur_nonce;
            end
        end
    end

    // Job fields are pure data: only loaded on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (accept_job) begin
            mid_q  <= midstate;
            tail_q <= tail;
            end_q  <= nonce_end;
        end
    end

endmodule

// File: tb/tb_sha256_miner_ctrl.sv
// Bench for sha256_miner_ctrl: behavioural SHA-256 chunk core plus a scoreboard of
// expected found/done events, driven with the Bitcoin genesis block header.
module tb_sha256_miner_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, abort;
    logic [255:0] midstate;
    logic [95:0]  tail;
    logic [31:0]  nonce_start, nonce_end;
    logic [511:0] core_data;
    logic [255:0] core_vin;
    logic [255:0] core_hash = '0;
    logic         core_valid;
    logic         busy, found, done;
    logic [31:0]  found_nonce, cur_nonce;

    sha256_miner_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .midstate(midstate), .tail(tail), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .core_data(core_data), .core_vin(core_vin), .core_hash(core_hash), .core_valid(core_valid),
        .busy(busy), .found(found), .found_nonce(found_nonce), .done(done), .cur_nonce(cur_nonce)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] IV_CANON = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    // Genesis header bytes 0..63 (version, zero prev hash, first 28 merkle-root bytes).
    localparam logic [511:0] CHUNK1 = {32'h01000000, 256'h0,
        224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
    localparam logic [95:0]  GEN_TAIL  = 96'h1d00ffff_495fab29_4a5e1e4b;
    localparam logic [31:0]  GEN_NONCE = 32'h7c2bac1d;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Canonical compression: H0 and W0 in the most significant words.
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] vin_to_canon(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] data_to_canon(input logic [511:0] dd);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(dd[32*i +: 32]);
        return r;
    endfunction

    // Chunk core model: valid every 64 cycles, result of the chunk latched at the previous valid.
    logic [5:0] vcnt = 6'd0;
    int cyc = 0;
    int vbusy = 0;
    assign core_valid = (vcnt == 6'd63);

    always @(posedge clk) begin
        vcnt <= vcnt + 6'd1;
        cyc  <= cyc + 1;
        if (core_valid === 1'b1) begin
            core_hash <= sha_compress(vin_to_canon(core_vin), data_to_canon(core_data));
            if (busy === 1'b1) vbusy <= vbusy + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] found_q [$];
    logic        done_q [$];
    logic [31:0] seq_q [$];
    logic        seq_en = 1'b0;
    logic        seq_first = 1'b0;
    logic [31:0] seq_last = '0;
    int t0 = 0;
    int vb0 = 0;

    always @(negedge clk) begin
        if (found === 1'b1) begin
            check_eq("found_expected", found_q.size() > 0, 1);
            if (found_q.size() > 0) check_eq("found_nonce", found_nonce, found_q.pop_front());
        end
        if (done === 1'b1) begin
            check_eq("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) check_eq("found_with_done", found, done_q.pop_front());
        end
        if (seq_en && busy === 1'b1 && (seq_first || cur_nonce != seq_last)) begin
            check_eq("nonce_seq_pending", seq_q.size() > 0, 1);
            if (seq_q.size() > 0) check_eq("nonce_seq", cur_nonce, seq_q.pop_front());
            seq_last  = cur_nonce;
            seq_first = 1'b0;
        end
    end

    task automatic start_job(input logic [31:0] ns, input logic [31:0] ne, input bit align);
        @(posedge clk); #1;
        if (align) while (vcnt != 6'd63) begin @(posedge clk); #1; end
        nonce_start = ns;
        nonce_end   = ne;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        vb0   = vbusy;
    endtask

    task automatic wait_done(input int max, output int lat);
        int n = 0;
        lat = -1;
        while (n < max) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            n++;
        end
        check_eq("done_within_bound", lat >= 0, 1);
    endtask

    task automatic wait_passes(input int n);
        int guard = 0;
        while (vbusy < vb0 + n && guard < 300) begin @(posedge clk); #1; guard++; end
        check_eq("pass_progress", vbusy >= vb0 + n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [255:0] m;
        int lat;
        m = sha_compress(IV_CANON, CHUNK1);
        for (int i = 0; i < 8; i++) midstate[32*i +: 32] = m[255-32*i -: 32];
        tail = GEN_TAIL;
        reset = 1'b1; start = 1'b0; abort = 1'b0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_found", found, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_found_nonce", found_nonce, 0);
        check_eq("rst_cur_nonce", cur_nonce, 0);
        check_eq("rst_core_data", |core_data, 0);
        check_eq("rst_core_vin", |core_vin, 0);

        // Genesis nonce alone: found and done together.
        found_q.push_back(GEN_NONCE);
        done_q.push_back(1'b1);
        start_job(GEN_NONCE, GEN_NONCE, 1'b0);
        @(negedge clk);
        check_eq("busy_after_start", busy, 1);
        check_eq("latched_nonce", cur_nonce, GEN_NONCE);
        if (core_valid === 1'b0) check_eq("wait_outputs_zero", |{core_data, core_vin}, 0);
        wait_done(300, lat);
        check_eq("single_latency_ok", (lat >= 128) && (lat <= 192), 1);
        repeat (3) @(negedge clk);
        check_eq("found_nonce_held", found_nonce, GEN_NONCE);
        check_eq("idle_after_done", busy, 0);

        // Five-nonce range around the genesis nonce: one hit mid-range.
        found_q.push_back(GEN_NONCE);
        done_q.push_back(1'b0);
        start_job(GEN_NONCE - 32'd2, GEN_NONCE + 32'd2, 1'b0);
        wait_done(900, lat);
        check_eq("range_latency_ok", (lat >= 640) && (lat <= 704), 1);

        // Wrapping range, start coinciding with core_valid.
        seq_q = '{32'hfffffffe, 32'hffffffff, 32'h00000000, 32'h00000001};
        seq_first = 1'b1;
        seq_en = 1'b1;
        done_q.push_back(1'b0);
        start_job(32'hfffffffe, 32'h00000001, 1'b1);
        wait_done(800, lat);
        seq_en = 1'b0;
        check_eq("wrap_latency", lat, 576);
        check_eq("wrap_seq_consumed", seq_q.size(), 0);

        // Abort beats start in IDLE.
        @(posedge clk); #1;
        nonce_start = 32'h55; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("abort_beats_start_busy", busy, 0);
        check_eq("abort_beats_start_nonce", cur_nonce, 32'h1);

        // Start ignored while busy, then abort one cycle before the P2 evaluation.
        start_job(32'h100, 32'h1ff, 1'b0);
        nonce_start = 32'h500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("busy_start_ignored", cur_nonce, 32'h100);
        check_eq("busy_still", busy, 1);
        wait_passes(2);
        while (vcnt != 6'd62) begin @(posedge clk); #1; end
        abort = 1'b1; start = 1'b1; nonce_start = 32'h600;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_found_nonce_kept", found_nonce, GEN_NONCE);
        check_eq("abort_cur_nonce", cur_nonce, 32'h100);
        repeat (70) @(negedge clk);
        found_q.push_back(GEN_NONCE);
        done_q.push_back(1'b1);
        start_job(GEN_NONCE, GEN_NONCE, 1'b0);
        wait_done(300, lat);
        check_eq("restart_latency_ok", (lat >= 128) && (lat <= 192), 1);

        // Reset during pass 1.
        start_job(32'h100, 32'h1ff, 1'b0);
        wait_passes(1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("p1rst_busy", busy, 0);
        check_eq("p1rst_found", found, 0);
        check_eq("p1rst_done", done, 0);
        check_eq("p1rst_found_nonce", found_nonce, 0);
        check_eq("p1rst_cur_nonce", cur_nonce, 0);
        check_eq("p1rst_core_data", |core_data, 0);
        check_eq("p1rst_core_vin", |core_vin, 0);

        repeat (140) @(negedge clk);
        check_eq("found_q_empty", found_q.size(), 0);
        check_eq("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
